keypad_entry_decoder: RTL
=========================

Name: keypad_entry_decoder

Overview:
Consumes the 4-bit key code and valid flag produced by the keypad encoder. Debounces them, turns each stable press into exactly one key event, and decodes that event into a digit, backspace or enter. Assembles digits into a PIN buffer that the lock controller reads. Sits between the keypad encoder and the safe-lock FSM.

Parameters:
PIN_LEN, 4, number of digits in a complete PIN (legal range 1..8).
STABLE_CYCLES, 3, consecutive identical samples needed to accept a press, and consecutive valid=0 samples needed to accept a release (legal range 1..255).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
code  in  4  encoder key code: 0-9 digits, 10 '*' (backspace), 11 '#' (enter), 14 no-key filler; any other value is illegal.
valid  in  1  encoder valid; at least one key is pressed.
clear  in  1  synchronous clear of the buffer, driven by the controller.
ack  in  1  controller has consumed the PIN.
key_event  out  1  one-cycle pulse per accepted press.
key_code  out  4  code of the last accepted press; held until the next accept.
pin  out  4*PIN_LEN  digit buffer; newest digit in the LS nibble, unused nibbles zero.
digit_count  out  CW  digits held, CW = $clog2(PIN_LEN+1) (3 at default).
pin_ready  out  1  a full PIN was entered with '#'; held until ack or clear.
err_pulse  out  1  one-cycle pulse on overflow, short enter, illegal code, or backspace on empty.

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM in IDLE; debounce counter 0; sample register 0.
- FSM states:
  - IDLE: on valid=1, latch code into the sample register, set counter=1, go to DEBOUNCE.
  - DEBOUNCE: if valid=0, go to IDLE. If code differs from the sample, relatch it and set counter=1. Otherwise increment the counter. When the counter reaches STABLE_CYCLES, accept the press and go to HELD.
  - HELD: code changes are ignored. Each valid=0 sample increments the release counter; any valid=1 sample resets it to 0. At STABLE_CYCLES, go to IDLE.
- Counter rules:
  - The counter saturates; it never wraps.
  - With STABLE_CYCLES=1, IDLE accepts directly on the first valid=1 sample and goes to HELD.
- Accept timing:
  - key_event and key_code are registered.
  - If valid rises before edge 1 and stays stable, key_event is high for exactly the cycle after edge STABLE_CYCLES.
  - No second event occurs until a full release is observed.
- Decode on accept (same edge as key_event):
  - Digit 0-9, digit_count<PIN_LEN, pin_ready=0: pin <= {pin shifted left 4, digit}; digit_count+1.
  - Digit with digit_count==PIN_LEN: buffer unchanged; err_pulse.
  - '*' with digit_count>0: pin shifted right 4, MS nibble zero; digit_count-1.
  - '*' with digit_count==0: buffer unchanged; err_pulse.
  - '#' with digit_count==PIN_LEN: pin_ready <= 1.
  - '#' with digit_count<PIN_LEN: buffer unchanged; err_pulse.
  - Any other code: key_event still pulses; buffer unchanged; err_pulse.
- While pin_ready=1:
  - All accepts still produce key_event.
  - The buffer is locked; no err_pulse is raised.
- ack:
  - When pin_ready=1, ack clears pin, digit_count and pin_ready on the next edge.
  - ack is ignored when pin_ready=0.
- clear:
  - Zeroes pin, digit_count and pin_ready on the next edge.
  - Has priority over ack and over a decode in the same cycle. A coincident key_event still pulses, but its decode is discarded and no err_pulse is raised.
  - Does not affect the FSM.
- Mid-operation reset: immediate return to reset values. A key still held after rst falls is treated as a new press, debounced from IDLE.

Decomposition:
- The shared team params header holds the key code constants: KEY_STAR=10, KEY_HASH=11, KEY_NONE=14.
- It also holds the FSM state encodings IDLE/DEBOUNCE/HELD.
- One sub-module, keypad_debouncer: FSM, counters, key_event and key_code.
- The top level holds the PIN buffer and decode logic.

Test Plan:
- rst, then code=5, valid=1 for 3 cycles, then valid=0 for 3 cycles -> one key_event with key_code=5, digit_count=1, pin=16'h0005.
- valid=1 with code toggling 2/3 every cycle for 10 cycles -> no key_event; then code=3 held stable -> key_event after 3 samples.
- Enter 1,2,3,4 then '#' -> pin=16'h1234, digit_count=4, pin_ready=1; then digit 9 -> key_event, no change, no err_pulse; then ack -> pin=0, digit_count=0, pin_ready=0.
- Enter 1,2 then '*' -> pin=16'h0001, digit_count=1; then '*' twice -> second '*' gives err_pulse, digit_count stays 0.
- Enter 7 then '#' -> err_pulse, pin_ready=0. Enter 4 digits then a 5th -> err_pulse, pin unchanged.
- Assert rst mid-DEBOUNCE with valid=1 held -> outputs 0 immediately; after release of rst, key_event only after 3 fresh samples. Assert clear together with ack -> buffer zeroed; clear wins.

Source files
------------

// File: rtl/keypad_entry_decoder_pkg.sv
// Shared key codes, debouncer state encodings and a digit classifier.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package keypad_entry_decoder_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;  // backspace
  localparam logic [3:0] KEY_HASH = 4'd11;  // enter
  localparam logic [3:0] KEY_NONE = 4'd14;  // encoder no-key filler, never a legal press

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] c);
    return (c <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_entry_decoder_debouncer.sv
// Debounces encoder code/valid and emits one registered key event per stable press.
// Latency: key_event rises the cycle after the STABLE_CYCLES-th identical valid sample.
// Backpressure: none; a new press is only taken after STABLE_CYCLES released samples.
module keypad_debouncer
  import keypad_entry_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_code,
  input  logic       i_valid,
  output logic       o_accept,
  output logic [3:0] o_accept_code,
  output logic       o_key_event,
  output logic [3:0] o_key_code
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_sample;
  logic       r_key_event;
  logic [3:0] r_key_code;

  logic [7:0] w_cnt_inc;
  logic       w_stable_hit;
  logic       w_accept;

  // Saturating increment shared by press and release counting.
  assign w_cnt_inc    = (r_cnt == 8'hFF) ? r_cnt : (r_cnt + 8'd1);
  assign w_stable_hit = (w_cnt_inc >= STABLE_C);

  // Accept strobe for this edge; the top decodes on the same edge key_event is registered.
  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      IDLE:     w_accept = i_valid && (STABLE_C == 8'd1);
      DEBOUNCE: w_accept = i_valid && (i_code == r_sample) && w_stable_hit;
      default:  w_accept = 1'b0;
    endcase
  end

  // Press/release FSM with registered event outputs; r_cnt is the release counter in HELD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_sample    <= 4'd0;
      r_key_event <= 1'b0;
      r_key_code  <= 4'd0;
    end else begin
      r_key_event <= 1'b0;
      if (w_accept) begin
        r_key_event <= 1'b1;
        r_key_code  <= i_code;
      end
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_sample <= i_code;
            if (w_accept) begin
              r_state <= HELD;
              r_cnt   <= 8'd0;
            end else begin
              r_state <= DEBOUNCE;
              r_cnt   <= 8'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (!i_valid) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
          end else if (i_code != r_sample) begin
            r_sample <= i_code;
            r_cnt    <= 8'd1;
          end else if (w_accept) begin
            r_state <= HELD;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        HELD: begin
          if (i_valid) begin
            r_cnt <= 8'd0;
          end else if (w_stable_hit) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign o_accept      = w_accept;
  assign o_accept_code = i_code;
  assign o_key_event   = r_key_event;
  assign o_key_code    = r_key_code;

endmodule

// File: rtl/keypad_entry_decoder.sv
// Debounced keypad entry: decodes accepted keys into a PIN buffer for the lock controller.
// Latency: buffer, pin_ready and err_pulse update on the same edge that raises key_event.
// Backpressure: none; presses while pin_ready is set are reported but do not touch the buffer.
module keypad_entry_decoder
  import keypad_entry_decoder_pkg::*;
#(
  parameter int PIN_LEN       = 4,
  parameter int STABLE_CYCLES = 3,
  localparam int CW           = $clog2(PIN_LEN + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [3:0]             i_code,
  input  logic                   i_valid,
  input  logic                   i_clear,
  input  logic                   i_ack,
  output logic                   o_key_event,
  output logic [3:0]             o_key_code,
  output logic [4*PIN_LEN-1:0]   o_pin,
  output logic [CW-1:0]          o_digit_count,
  output logic                   o_pin_ready,
  output logic                   o_err_pulse
);

  localparam int PW = 4 * PIN_LEN;

  logic          w_accept;
  logic [3:0]    w_acc_code;
  logic [PW-1:0] w_digit_ext;
  logic          w_full;
  logic          w_empty;

  logic [PW-1:0] r_pin;
  logic [CW-1:0] r_count;
  logic          r_ready;
  logic          r_err;

  keypad_debouncer #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debouncer (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_code        (i_code),
    .i_valid       (i_valid),
    .o_accept      (w_accept),
    .o_accept_code (w_acc_code),
    .o_key_event   (o_key_event),
    .o_key_code    (o_key_code)
  );

  assign w_digit_ext = PW'(w_acc_code);
  assign w_full      = (r_count == CW'(PIN_LEN));
  assign w_empty     = (r_count == '0);

  // PIN buffer: clear beats ack beats decode; the buffer is frozen while a PIN is pending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pin   <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_clear || (i_ack && r_ready)) begin
        r_pin   <= '0;
        r_count <= '0;
        r_ready <= 1'b0;
      end else if (w_accept && !r_ready) begin
        if (is_digit(w_acc_code)) begin
          // Unused nibbles are zero, so the left shift never loses a held digit.
          if (!w_full) begin
            r_pin   <= (r_pin << 4) | w_digit_ext;
            r_count <= r_count + CW'(1);
          end else begin
            r_err <= 1'b1;
          end
        end else if (w_acc_code == KEY_STAR) begin
          if (!w_empty) begin
            r_pin   <= r_pin >> 4;
            r_count <= r_count - CW'(1);
          end else begin
            r_err <= 1'b1;
          end
        end else if (w_acc_code == KEY_HASH) begin
          if (w_full) begin
            r_ready <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end else begin
          // KEY_NONE and the unassigned codes land here as illegal presses.
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_pin         = r_pin;
  assign o_digit_count = r_count;
  assign o_pin_ready   = r_ready;
  assign o_err_pulse   = r_err;

endmodule
